// File: rtl/pad_pkg.sv
// Shared pad-side definitions: GPIO register indices and per-pin interrupt
// edge configuration.
package pad_pkg;

    // Register indices on the GPIO register bus
    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_OE      = 3'd1;
    localparam logic [2:0] GPIO_PU      = 3'd2;
    localparam logic [2:0] GPIO_IN      = 3'd3;
    localparam logic [2:0] GPIO_INTEN_R = 3'd4;
    localparam logic [2:0] GPIO_INTEN_F = 3'd5;
    localparam logic [2:0] GPIO_INTSTAT = 3'd6;
    localparam logic [2:0] GPIO_DBCFG   = 3'd7;

    // One bit per edge polarity; used both for detected events and enables
    typedef struct packed {
        logic rise;
        logic fall;
    } gpio_irqcfg_t;

endpackage

// File: rtl/ioif.sv
// Single-pin pad interface. The controller side uses the drive modport
// (po/oe/pu out, pi in); the pad model uses the pad modport.
interface ioif;
    logic po;
    logic oe;
    logic pu;
    logic pi;

    modport drive (output po, output oe, output pu, input pi);
    modport pad   (input po, input oe, input pu, output pi);
endinterface

// File: rtl/gpio_in_filter.sv
// Per-pin input conditioning: synchroniser, optional debounce filter and
// edge detection on the filtered value.
// Optional feature macro: GPIO_DEBOUNCE_EN (adds a DBW-bit stability counter
// per pin; without it the filtered value follows the synchroniser directly).
module gpio_in_filter
    import pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DBW         = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pi,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [DBW-1:0] dbcfg,
`endif
    output logic           f,
    output logic           rise,
    output logic           fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   f_q;
    logic                   f_d_q;

    // Synchroniser chain; idles high to match an undriven pad
    // NOTE: flops use non-blocking assignments so every stage samples the
    // previous stage's old value and the chain really delays by one per stage.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], pi};
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [DBW-1:0] cnt_q;

    // Debounce: f follows s only after s has differed for dbcfg+1 cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            f_q   <= 1'b1;
            cnt_q <= '0;
        end else if (s == f_q) begin
            cnt_q <= '0;
        end else if (cnt_q == dbcfg) begin
            f_q   <= s;
            cnt_q <= '0;
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    // Without debounce the filtered value is the synchroniser output, one cycle later
    always_ff @(posedge clk) begin
        if (reset) f_q <= 1'b1;
        else       f_q <= s;
    end
`endif

    // Delayed copy of the filtered value for edge detection
    always_ff @(posedge clk) begin
        if (reset) f_d_q <= 1'b1;
        else       f_d_q <= f_q;
    end

    assign f    = f_q;
    assign rise = f_q & ~f_d_q;
    assign fall = ~f_q & f_d_q;

endmodule

// File: rtl/gpio_ioif_ctrl.sv
// Register-programmable GPIO controller driving an array of ioif pads.
// Pad outputs come straight from register flops; inputs are synchronised,
// optionally debounced (macro GPIO_DEBOUNCE_EN), edge-detected and recorded
// in a sticky write-one-to-clear interrupt status register.
module gpio_ioif_ctrl
    import pad_pkg::*;
#(
    parameter int IOC         = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DBW         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        irq,
    ioif.drive          ioifdrv [0:IOC-1]
);

    logic [IOC-1:0] out_q;
    logic [IOC-1:0] oe_q;
    logic [IOC-1:0] pu_q;
    logic [IOC-1:0] inten_r_q;
    logic [IOC-1:0] inten_f_q;
    logic [IOC-1:0] intstat_q;
    logic [DBW-1:0] dbcfg_q;

    logic [IOC-1:0] wr_bits;
    logic [IOC-1:0] w1c;
    logic [IOC-1:0] pi_vec;
    logic [IOC-1:0] f_vec;
    logic [IOC-1:0] rise_vec;
    logic [IOC-1:0] fall_vec;
    logic [IOC-1:0] set_vec;
    logic [31:0]    rd_mux;
    logic [31:0]    rd_data_q;
    logic           rd_valid_q;
    logic           irq_q;
    logic           unused_wr_data;

    // Bits of wr_data above IOC carry no meaning for any register
    assign wr_bits        = wr_data[IOC-1:0];
    assign unused_wr_data = ^wr_data;

    assign w1c = (wr_en && (wr_addr == GPIO_INTSTAT)) ? wr_bits : '0;

    for (genvar i = 0; i < IOC; i++) begin : g_pin
        gpio_irqcfg_t evt;
        gpio_irqcfg_t en;

        assign ioifdrv[i].po = out_q[i];
        assign ioifdrv[i].oe = oe_q[i];
        assign ioifdrv[i].pu = pu_q[i];
        assign pi_vec[i]     = ioifdrv[i].pi;

        gpio_in_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .DBW         (DBW)
        ) u_filter (
            .clk   (clk),
            .reset (reset),
            .pi    (pi_vec[i]),
`ifdef GPIO_DEBOUNCE_EN
            .dbcfg (dbcfg_q),
`endif
            .f     (f_vec[i]),
            .rise  (rise_vec[i]),
            .fall  (fall_vec[i])
        );

        assign evt        = '{rise: rise_vec[i],  fall: fall_vec[i]};
        assign en         = '{rise: inten_r_q[i], fall: inten_f_q[i]};
        assign set_vec[i] = |(evt & en);
    end

    // Plain read/write registers; reset values put the pads in the idle-driver state
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q     <= '1;
            oe_q      <= '0;
            pu_q      <= '1;
            inten_r_q <= '0;
            inten_f_q <= '0;
            dbcfg_q   <= '0;
        end else if (wr_en) begin
            case (wr_addr)
                GPIO_OUT:     out_q     <= wr_bits;
                GPIO_OE:      oe_q      <= wr_bits;
                GPIO_PU:      pu_q      <= wr_bits;
                GPIO_INTEN_R: inten_r_q <= wr_bits;
                GPIO_INTEN_F: inten_f_q <= wr_bits;
                GPIO_DBCFG:   dbcfg_q   <= wr_data[DBW-1:0];
                default:      ;
            endcase
        end
    end

    // Sticky interrupt status: a new event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (reset) intstat_q <= '0;
        else       intstat_q <= (intstat_q & ~w1c) | set_vec;
    end

    // Registered interrupt line from the enabled status bits
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= |(intstat_q & (inten_r_q | inten_f_q));
    end

    // Read multiplexer over the current (pre-write) register state
    // NOTE: rd_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            GPIO_OUT:     rd_mux = 32'(out_q);
            GPIO_OE:      rd_mux = 32'(oe_q);
            GPIO_PU:      rd_mux = 32'(pu_q);
            GPIO_IN:      rd_mux = 32'(f_vec);
            GPIO_INTEN_R: rd_mux = 32'(inten_r_q);
            GPIO_INTEN_F: rd_mux = 32'(inten_f_q);
            GPIO_INTSTAT: rd_mux = 32'(intstat_q);
            GPIO_DBCFG:   rd_mux = 32'(dbcfg_q);
            default:      rd_mux = '0;
        endcase
    end

    // Read response one cycle after the strobe; data holds between reads
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule
